// File: rtl/l2_bank_ctrl.sv
// Single-bank L2 controller: turns a granted TCDM request into one SRAM access with a
// fixed one-cycle response, flags out-of-range accesses and runs the idle sleep/wake FSM.
module l2_bank_ctrl #(
    parameter int          NR_BANKS          = 4,
    parameter int          BANK_WORDS        = 8192,
    parameter logic [31:0] BASE_ADDR         = 32'h1C00_0000,
    parameter int          IDLE_SLEEP_CYCLES = 64,
    parameter int          WAKE_CYCLES       = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sleep_en_i,
    input  logic                          req_i,
    input  logic [31:0]                   add_i,
    input  logic                          wen_i,
    input  logic [31:0]                   wdata_i,
    input  logic [3:0]                    be_i,
    output logic                          gnt_o,
    output logic                          r_valid_o,
    output logic [31:0]                   r_rdata_o,
    output logic                          r_opc_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [$clog2(BANK_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    output logic [3:0]                    mem_be_o,
    input  logic [31:0]                   mem_rdata_i,
    output logic                          mem_sleep_o
);

    localparam int IL_W   = $clog2(NR_BANKS);
    localparam int AW     = $clog2(BANK_WORDS);
    localparam int IDLE_W = $clog2(IDLE_SLEEP_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(IDLE_SLEEP_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST    = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [32:0]       REGION_BYTES = 33'(NR_BANKS) * 33'(BANK_WORDS) * 33'd4;
    localparam logic [31:0]       ERR_RDATA    = 32'hBADC_AB1E;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [WAKE_W-1:0] r_wake_cnt;
    logic              r_mem_sleep;
    logic              r_vld_q;
    logic              r_rd_q;
    logic              r_err_q;

    logic [31:0]       w_off;
    logic              w_in_range;
    logic              w_gnt;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_off      = add_i - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < REGION_BYTES);
    assign w_gnt      = req_i && (r_state == ST_ACTIVE);

    assign gnt_o       = w_gnt;
    assign mem_req_o   = w_gnt && w_in_range;
    assign mem_we_o    = mem_req_o && !wen_i;
    assign mem_addr_o  = w_off[2+IL_W +: AW];
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;
    assign mem_sleep_o = r_mem_sleep;
    assign r_valid_o   = r_vld_q;

    // The idle counter saturates at the expiry value, so raising sleep_en_i after a
    // long idle stretch puts the bank to sleep on the next idle cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_ACTIVE;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            r_mem_sleep <= 1'b0;
            r_vld_q     <= 1'b0;
            r_rd_q      <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_vld_q <= w_gnt;
            r_rd_q  <= wen_i;
            r_err_q <= !w_in_range;

            case (r_state)
                ST_ACTIVE: begin
                    if (req_i) begin
                        r_idle_cnt <= '0;
                    end else begin
                        if (r_idle_cnt != IDLE_LAST) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                        if (sleep_en_i && (r_idle_cnt == IDLE_LAST)) begin
                            r_state     <= ST_SLEEP;
                            r_mem_sleep <= 1'b1;
                        end
                    end
                end
                ST_SLEEP: begin
                    if (req_i || !sleep_en_i) begin
                        r_state     <= ST_WAKE;
                        r_wake_cnt  <= '0;
                        r_mem_sleep <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt == WAKE_LAST) begin
                        r_state    <= ST_ACTIVE;
                        r_idle_cnt <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ACTIVE;
                    r_mem_sleep <= 1'b0;
                end
            endcase
        end
    end

    // Response data is forced to zero whenever no response is being presented.
    always_comb begin
        r_rdata_o = '0;
        r_opc_o   = 1'b0;
        if (r_vld_q) begin
            if (r_err_q) begin
                r_rdata_o = ERR_RDATA;
                r_opc_o   = 1'b1;
            end else if (r_rd_q) begin
                r_rdata_o = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// Directed bench for l2_bank_ctrl: stimulus pushes expected responses into a queue and an
// independent monitor pops and compares them whenever r_valid_o is seen.
module tb_l2_bank_ctrl;

    logic        clk;
    logic        rst;
    logic        sleep_en;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_sleep;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic [31:0] sram [0:8191];

    l2_bank_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sleep_en_i  (sleep_en),
        .req_i       (req),
        .add_i       (add),
        .wen_i       (wen),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .r_valid_o   (r_valid),
        .r_rdata_o   (r_rdata),
        .r_opc_o     (r_opc),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata),
        .mem_sleep_o (mem_sleep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8192; i++) sram[i] = 32'h0;
        mem_rdata = 32'h0;
    end

    // Single-port SRAM with byte enables and a registered read port.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every r_valid_o must match the oldest expected response.
    always @(negedge clk) begin
        logic [32:0] e;
        if (r_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_unexpected: got valid rdata=%h opc=%0d, expected no response", r_rdata, r_opc);
            end else begin
                e = exp_q.pop_front();
                $display("resp rdata=%h opc=%0d (expected %h/%0d)", r_rdata, r_opc, e[32:1], e[0]);
                check("resp_rdata", r_rdata, e[32:1]);
                check("resp_opc", 32'(r_opc), 32'(e[0]));
            end
        end else begin
            check("idle_resp_zero", {r_rdata[31:1], r_rdata[0] | r_opc}, 32'h0);
        end
    end

    // Issue one access in the current cycle (expected to be granted), check the SRAM side,
    // queue the expected response and return one cycle later with req dropped.
    task automatic access(input string tag, input logic t_wen, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic [3:0] t_be,
                          input logic exp_mreq, input logic [12:0] exp_addr,
                          input logic [31:0] exp_rdata, input logic exp_opc);
        req   = 1'b1;
        wen   = t_wen;
        add   = t_addr;
        wdata = t_wdata;
        be    = t_be;
        @(negedge clk);
        $display("txn %s %s addr=%h wdata=%h be=%b", tag, t_wen ? "RD" : "WR", t_addr, t_wdata, t_be);
        check({tag, "_gnt"}, 32'(gnt), 32'h1);
        check({tag, "_mem_req"}, 32'(mem_req), 32'(exp_mreq));
        if (exp_mreq) begin
            check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
            check({tag, "_mem_we"}, 32'(mem_we), 32'(!t_wen));
            check({tag, "_mem_be"}, 32'(mem_be), 32'(t_be));
            check({tag, "_mem_wdata"}, mem_wdata, t_wdata);
        end
        exp_q.push_back({exp_rdata, exp_opc});
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sleep_en = 1'b0; req = 1'b0; add = 32'h0;
        wen = 1'b1; wdata = 32'h0; be = 4'h0;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_r_valid", 32'(r_valid), 32'h0);
        check("rst_r_rdata", r_rdata, 32'h0);
        check("rst_r_opc", 32'(r_opc), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_sleep", 32'(mem_sleep), 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Read/write path, back to back
        access("wr_beef", 1'b0, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 13'd1, 32'h0, 1'b0);
        access("rd_beef", 1'b1, 32'h1C00_0010, 32'h0, 4'hF, 1'b1, 13'd1, 32'hDEAD_BEEF, 1'b0);
        // Interleave bits are ignored: same bank word
        access("rd_ilv", 1'b1, 32'h1C00_0014, 32'h0, 4'hF, 1'b1, 13'd1, 32'hDEAD_BEEF, 1'b0);

        // Byte enables
        access("wr_be1", 1'b0, 32'h1C00_0020, 32'h0000_AB00, 4'b0010, 1'b1, 13'd2, 32'h0, 1'b0);
        access("rd_be1", 1'b1, 32'h1C00_0020, 32'h0, 4'hF, 1'b1, 13'd2, 32'h0000_AB00, 1'b0);
        access("wr_be0", 1'b0, 32'h1C00_0020, 32'hFFFF_FF77, 4'b0001, 1'b1, 13'd2, 32'h0, 1'b0);
        access("rd_be0", 1'b1, 32'h1C00_0020, 32'h0, 4'hF, 1'b1, 13'd2, 32'h0000_AB77, 1'b0);

        // Top word in range, then out of range above and below
        access("rd_top", 1'b1, 32'h1C01_FFFC, 32'h0, 4'hF, 1'b1, 13'h1FFF, 32'h0, 1'b0);
        access("rd_oor_hi", 1'b1, 32'h1C02_0000, 32'h0, 4'hF, 1'b0, 13'd0, 32'hBADC_AB1E, 1'b1);
        access("rd_oor_lo", 1'b1, 32'h1BFF_FFFC, 32'h0, 4'hF, 1'b0, 13'd0, 32'hBADC_AB1E, 1'b1);
        access("wr_oor_hi", 1'b0, 32'h1C02_0004, 32'h1234_5678, 4'hF, 1'b0, 13'd0, 32'hBADC_AB1E, 1'b1);
        next_cycle();

        // Request in the 64th idle cycle wins over sleep
        sleep_en = 1'b1;
        access("rd_pre64", 1'b1, 32'h1C00_0010, 32'h0, 4'hF, 1'b1, 13'd1, 32'hDEAD_BEEF, 1'b0);
        repeat (63) next_cycle();
        access("rd_at64", 1'b1, 32'h1C00_0020, 32'h0, 4'hF, 1'b1, 13'd2, 32'h0000_AB77, 1'b0);
        sleep_en = 1'b0;
        @(negedge clk);
        check("no_sleep_after_req64", 32'(mem_sleep), 32'h0);
        next_cycle();

        // sleep_en low: long idle stretch never sleeps
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("sleep_en_low_idle", 32'(mem_sleep), 32'h0);
            next_cycle();
        end

        // Sleep after exactly 64 idle cycles, then wake on a held request
        sleep_en = 1'b1;
        access("rd_pre_sleep", 1'b1, 32'h1C00_0020, 32'h0, 4'hF, 1'b1, 13'd2, 32'h0000_AB77, 1'b0);
        repeat (63) next_cycle();
        @(negedge clk);
        check("sleep_idle64", 32'(mem_sleep), 32'h0);
        next_cycle();
        req = 1'b1; wen = 1'b1; add = 32'h1C00_0010; be = 4'hF;
        @(negedge clk);
        check("sleep_entered", 32'(mem_sleep), 32'h1);
        check("sleep_gnt", 32'(gnt), 32'h0);
        check("sleep_mem_req", 32'(mem_req), 32'h0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            check("wake_gnt", 32'(gnt), 32'h0);
            check("wake_mem_req", 32'(mem_req), 32'h0);
            check("wake_mem_sleep", 32'(mem_sleep), 32'h0);
        end
        next_cycle();
        @(negedge clk);
        $display("txn wake_rd RD addr=%h", add);
        check("wake_grant", 32'(gnt), 32'h1);
        check("wake_grant_mem_req", 32'(mem_req), 32'h1);
        exp_q.push_back({32'hDEAD_BEEF, 1'b0});
        next_cycle();
        req = 1'b0;
        sleep_en = 1'b0;
        next_cycle();

        // Reset in the grant cycle of a read drops its response
        rst = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h1C00_0010;
        @(negedge clk);
        $display("txn rst_rd RD addr=%h with reset", add);
        check("rst_cycle_gnt", 32'(gnt), 32'h1);
        next_cycle();
        rst = 1'b0; req = 1'b0;
        sleep_en = 1'b1;
        @(negedge clk);
        check("rst_drops_resp", 32'(r_valid), 32'h0);

        // Reset during WAKE returns to ACTIVE
        repeat (64) next_cycle();
        @(negedge clk);
        check("sleep_after_rst_idle", 32'(mem_sleep), 32'h1);
        req = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("wake_rst_cycle_gnt", 32'(gnt), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        $display("txn post_wake_rst RD addr=%h", add);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        check("post_rst_mem_sleep", 32'(mem_sleep), 32'h0);
        exp_q.push_back({32'hDEAD_BEEF, 1'b0});
        next_cycle();
        req = 1'b0;
        sleep_en = 1'b0;
        @(negedge clk);
        check("post_rst_gnt_idle", 32'(gnt), 32'h0);

        repeat (3) next_cycle();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_bank_ctrl.md
# l2_bank_ctrl

Single-bank controller at one slave port of the interleaved L2 crossbar. It converts the granted TCDM request into a single-port SRAM access and returns the response exactly one cycle later, matching the crossbar's fixed response latency of 1 with write responses enabled. It also owns the bank's idle-sleep/wake power state machine and flags out-of-range accesses through `r_opc_o`. One instance sits per crossbar slave port.

## Interface
- `NR_BANKS`, default 4: number of interleaved banks; must be a power of two.
- `BANK_WORDS`, default 8192: 32-bit words per bank; must be a power of two.
- `BASE_ADDR`, default 32'h1C00_0000: byte base of the interleaved region.
- `IDLE_SLEEP_CYCLES`, default 64: consecutive idle cycles in ACTIVE before sleeping; ≥1.
- `WAKE_CYCLES`, default 4: cycles spent in WAKE; ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `sleep_en_i`  in  1  permits entry into SLEEP.
- `req_i`  in  1  TCDM request.
- `add_i`  in  32  byte address.
- `wen_i`  in  1  1 = read, 0 = write.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables.
- `gnt_o`  out  1  grant.
- `r_valid_o`  out  1  response valid.
- `r_rdata_o`  out  32  response data.
- `r_opc_o`  out  1  1 = error.
- `mem_req_o`  out  1  SRAM chip enable.
- `mem_we_o`  out  1  SRAM write enable.
- `mem_addr_o`  out  log2(BANK_WORDS)  bank-local word address.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_be_o`  out  4  SRAM byte enables.
- `mem_rdata_i`  in  32  SRAM read data, valid one cycle after `mem_req_o`.
- `mem_sleep_o`  out  1  SRAM retention/sleep.

## Operation
- Offset: `off = add_i - BASE_ADDR`, 32-bit, wrap-around.
- Range: the access is in range iff `off < NR_BANKS*BANK_WORDS*4`.
- Local address: `mem_addr_o = off[2+log2(NR_BANKS) +: log2(BANK_WORDS)]`.
- The interleave bits `off[2 +: log2(NR_BANKS)]` are ignored because the crossbar has already routed on them.
- State machine states: ACTIVE, SLEEP, WAKE. Reset state is ACTIVE with the idle counter at 0.
- ACTIVE:
  - `gnt_o = req_i`.
  - The idle counter clears on any `req_i` and increments on each cycle with `!req_i`, saturating.
  - When `sleep_en_i` is high, `!req_i`, and the counter equals `IDLE_SLEEP_CYCLES-1`, the block moves to SLEEP.
  - When `sleep_en_i` is low, the counter still counts, but no transition occurs.
- SLEEP:
  - `mem_sleep_o = 1` and `gnt_o = 0`.
  - `req_i` moves the block to WAKE.
  - If `sleep_en_i` drops, the block also moves to WAKE.
- WAKE:
  - `mem_sleep_o = 0` and `gnt_o = 0`.
  - The wake counter counts from 0. At `WAKE_CYCLES-1` the block moves to ACTIVE and clears the idle counter.
- Granted in-range request: `mem_req_o = 1`, `mem_we_o = !wen_i`, `mem_be_o = be_i`, `mem_wdata_o = wdata_i`. All of these are combinational from the inputs.
- Granted out-of-range request: `mem_req_o = 0`. The response is still produced, with `r_opc_o = 1` and `r_rdata_o = 32'hBADC_AB1E`.
- Registered response flags: `vld_q`, `rd_q`, `err_q`.
- Read response: `r_rdata_o = mem_rdata_i`, `r_opc_o = 0`.
- Write response: `r_rdata_o = 0`, `r_opc_o = 0`.
- When `r_valid_o = 0`: `r_rdata_o = 0` and `r_opc_o = 0`.
- `mem_req_o` must never be asserted while `mem_sleep_o = 1` or while in WAKE.

## Timing
- Reset values:
  - `gnt_o = 0` while `req_i = 0`.
  - `r_valid_o = 0`, `r_rdata_o = 0`, `r_opc_o = 0`.
  - `mem_req_o = 0`, `mem_sleep_o = 0`.
  - State ACTIVE.
- Grant latency: 0 in ACTIVE.
- Response: `r_valid_o` is high in cycle t+1 for every grant in cycle t, reads and writes alike. No backpressure.
- Back-to-back grants produce back-to-back responses.
- Wake: a request arriving in SLEEP at cycle t is granted at cycle t+1+`WAKE_CYCLES`, provided `req_i` is held.
- Simultaneous events:
  - A request in the same cycle the idle counter would expire wins: the block stays in ACTIVE and grants.
  - A grant in the last ACTIVE cycle still produces its response in the following cycle.
- `rst_i` asserted in cycle t: in cycle t+1, `r_valid_o = 0` (a pending response is dropped) and the state is ACTIVE, including from WAKE or SLEEP.

## Test plan
- Read/write path:
  - Stimulus: write `add_i = 32'h1C00_0010` with `wdata_i = 32'hDEAD_BEEF`, `be_i = 4'hF`; then read the same address.
  - Expected: `mem_addr_o = 1` on both accesses; the read returns `r_rdata_o = 32'hDEAD_BEEF`, `r_opc_o = 0`, one cycle after grant; the write response has `r_rdata_o = 0`.
- Byte enables:
  - Stimulus: write `be_i = 4'b0010`, `wdata_i = 32'h0000_AB00` over a word preset to 0.
  - Expected: a subsequent read returns `32'h0000_AB00`.
- Out of range:
  - Stimulus: read `32'h1C00_0000 + NR_BANKS*BANK_WORDS*4`.
  - Expected: `mem_req_o = 0`; next cycle `r_valid_o = 1`, `r_opc_o = 1`, `r_rdata_o = 32'hBADC_AB1E`.
  - Stimulus: read `32'h1BFF_FFFC`.
  - Expected: the same error response.
- Sleep/wake:
  - Stimulus: `sleep_en_i = 1`, idle for 64 cycles.
  - Expected: `mem_sleep_o` rises after the 64th idle cycle.
  - Stimulus: then raise `req_i` and hold it.
  - Expected: `gnt_o = 0` for 5 cycles, grant on the 6th, and no `mem_req_o` before the grant.
- Boundary:
  - Stimulus: `req_i` in the 64th idle cycle.
  - Expected: the request is granted and no sleep occurs.
  - Stimulus: `sleep_en_i = 0` with 200 idle cycles.
  - Expected: `mem_sleep_o` stays 0.
- Reset mid-operation:
  - Stimulus: assert `rst_i` in the grant cycle of a read.
  - Expected: `r_valid_o = 0` in the next cycle.
  - Stimulus: assert `rst_i` during WAKE.
  - Expected: ACTIVE and `gnt_o = req_i` after the reset cycle.
